// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, write-back port and ID/EX bundle of the decode stage
interface decode_stage_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       Inst;
    logic [31:0]       pc_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       pc_out;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [31:0]       imm_ext;
    logic [31:0]       jump_target;
    logic [REG_AW-1:0] dst;
    logic [2:0]        alu_op;
    logic              alu_src_imm;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic              illegal;
    modport slave (
        input  in_valid, Inst, pc_in, flush, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, pc_out, rs_val, rt_val, imm_ext, jump_target, dst, alu_op,
               alu_src_imm, reg_wr, mem_rd, mem_wr, branch, jump, illegal
    );
    modport master (
        output in_valid, Inst, pc_in, flush, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, pc_out, rs_val, rt_val, imm_ext, jump_target, dst, alu_op,
               alu_src_imm, reg_wr, mem_rd, mem_wr, branch, jump, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file read, instruction decode and registered ID/EX bundle
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic          clk,
    input logic          reset,
    decode_stage_if.slave bus
);
    localparam int NREG = 1 << REG_AW;
    logic [DATA_W-1:0] rf [NREG];
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [DATA_W-1:0] rs_rd, rt_rd;
    logic              xfer;
    logic [REG_AW-1:0] dst_d;
    logic [2:0]        alu_d;
    logic              src_d, wr_d, mrd_d, mwr_d, br_d, j_d, ill_d;
    assign op    = bus.Inst[31:26];
    assign funct = bus.Inst[5:0];
    assign rs_a  = REG_AW'(bus.Inst[25:21]);
    assign rt_a  = REG_AW'(bus.Inst[20:16]);
    assign rd_a  = REG_AW'(bus.Inst[15:11]);
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign xfer = bus.in_valid && bus.in_ready;
    assign rs_rd = (bus.wb_en && bus.wb_addr == rs_a && bus.wb_addr != '0) ? bus.wb_data : rf[rs_a];
    assign rt_rd = (bus.wb_en && bus.wb_addr == rt_a && bus.wb_addr != '0) ? bus.wb_data : rf[rt_a];
    // Opcode/funct decode; illegal encodings leave every control output at 0
    always_comb begin
        dst_d = '0;
        alu_d = 3'd0;
        src_d = 1'b0;
        wr_d  = 1'b0;
        mrd_d = 1'b0;
        mwr_d = 1'b0;
        br_d  = 1'b0;
        j_d   = 1'b0;
        ill_d = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20: alu_d = 3'd0;
                    6'h22: alu_d = 3'd1;
                    6'h24: alu_d = 3'd2;
                    6'h25: alu_d = 3'd3;
                    6'h2A: alu_d = 3'd4;
                    default: ill_d = 1'b1;
                endcase
                wr_d  = !ill_d;
                dst_d = ill_d ? '0 : rd_a;
            end
            6'h08: begin src_d = 1'b1; wr_d = 1'b1; dst_d = rt_a; end
            6'h23: begin src_d = 1'b1; wr_d = 1'b1; mrd_d = 1'b1; dst_d = rt_a; end
            6'h2B: begin src_d = 1'b1; mwr_d = 1'b1; end
            6'h04: begin alu_d = 3'd1; br_d = 1'b1; end
            6'h02: j_d = 1'b1;
            default: ill_d = 1'b1;
        endcase
    end
    // ID/EX bundle: load on transfer, hold on stall, drop valid on drain or flush
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.pc_out      <= '0;
            bus.rs_val      <= '0;
            bus.rt_val      <= '0;
            bus.imm_ext     <= '0;
            bus.jump_target <= '0;
            bus.dst         <= '0;
            bus.alu_op      <= '0;
            bus.alu_src_imm <= 1'b0;
            bus.reg_wr      <= 1'b0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.branch      <= 1'b0;
            bus.jump        <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (xfer) begin
            bus.out_valid   <= 1'b1;
            bus.pc_out      <= bus.pc_in;
            bus.rs_val      <= rs_rd;
            bus.rt_val      <= rt_rd;
            bus.imm_ext     <= {{16{bus.Inst[15]}}, bus.Inst[15:0]};
            bus.jump_target <= {bus.pc_in[31:28], bus.Inst[25:0], 2'b00};
            bus.dst         <= dst_d;
            bus.alu_op      <= alu_d;
            bus.alu_src_imm <= src_d;
            bus.reg_wr      <= wr_d;
            bus.mem_rd      <= mrd_d;
            bus.mem_wr      <= mwr_d;
            bus.branch      <= br_d;
            bus.jump        <= j_d;
            bus.illegal     <= ill_d;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
    // Register file write port; register 0 is never written so it always reads 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != '0) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed corner sequences and randomized model check
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [4:0]  dst;
        logic [2:0]  alu;
        logic [6:0]  ctrl;
    } bundle_t;
    typedef struct {
        logic [31:0] inst;
        bundle_t     exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[12];
    bit m_valid;
    bit m_known;
    bundle_t m_b;
    logic [31:0] m_rf [32];

    decode_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    decode_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bundle_t dut_b();
        return {bus.pc_out, bus.rs_val, bus.rt_val, bus.imm_ext, bus.jump_target, bus.dst, bus.alu_op,
                bus.alu_src_imm, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump, bus.illegal};
    endfunction

    function automatic bundle_t mk(logic [31:0] rs, logic [31:0] rt, logic [31:0] imm, logic [31:0] jt,
                                   logic [4:0] dst, logic [2:0] alu, logic [6:0] ctrl);
        return {32'h4000_0000, rs, rt, imm, jt, dst, alu, ctrl};
    endfunction

    function automatic string mnem(logic [31:0] inst);
        case (inst[31:26])
            6'h00: case (inst[5:0])
                       6'h20: return "add";
                       6'h22: return "sub";
                       6'h24: return "and";
                       6'h25: return "or";
                       6'h2A: return "slt";
                       default: return "bad";
                   endcase
            6'h08: return "addi";
            6'h23: return "lw";
            6'h2B: return "sw";
            6'h04: return "beq";
            6'h02: return "j";
            default: return "bad";
        endcase
    endfunction

    function automatic bundle_t ref_decode(logic [31:0] inst, logic [31:0] pc, logic [31:0] rsv, logic [31:0] rtv);
        bundle_t b;
        string m;
        string rtype[5];
        rtype = '{"add", "sub", "and", "or", "slt"};
        m = mnem(inst);
        b = '0;
        b.pc  = pc;
        b.rs  = rsv;
        b.rt  = rtv;
        b.imm = 32'(signed'(inst[15:0]));
        b.jt  = (pc & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
        for (int i = 0; i < 5; i++)
            if (m == rtype[i]) begin
                b.alu  = 3'(i);
                b.dst  = inst[15:11];
                b.ctrl = 7'b0100000;
            end
        if (m == "addi") begin b.dst = inst[20:16]; b.ctrl = 7'b1100000; end
        if (m == "lw")   begin b.dst = inst[20:16]; b.ctrl = 7'b1110000; end
        if (m == "sw")   b.ctrl = 7'b1001000;
        if (m == "beq")  begin b.alu = 3'd1; b.ctrl = 7'b0000100; end
        if (m == "j")    b.ctrl = 7'b0000010;
        if (m == "bad")  b.ctrl = 7'b0000001;
        return b;
    endfunction

    task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.Inst = '0;
        bus.pc_in = 32'h4000_0000;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wb(logic [4:0] a, logic [31:0] d);
        bus.wb_en = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        bus.wb_en = 1'b0;
    endtask

    task automatic send(logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.Inst = inst;
        tick();
        bus.in_valid = 1'b0;
        bus.wb_en = 1'b0;
        bus.flush = 1'b0;
    endtask

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 0) return '0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        op = ops[$urandom_range(0, 6)];
        fn = fns[$urandom_range(0, 5)];
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
        if (fn == 6'h00) fn = 6'($urandom);
        if (op == 6'h00)
            return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), fn};
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    initial begin
        bundle_t held;
        bit rdy, xfer;
        tbl[0]  = '{32'h0022_1820, mk(5, 7, 32'h0000_1820, 32'h4088_6080, 3, 0, 7'b0100000)};
        tbl[1]  = '{32'h8C25_FFFC, mk(5, 0, 32'hFFFF_FFFC, 32'h4097_FFF0, 5, 0, 7'b1110000)};
        tbl[2]  = '{32'h0041_2022, mk(7, 5, 32'h0000_2022, 32'h4104_8088, 4, 1, 7'b0100000)};
        tbl[3]  = '{32'h0021_2824, mk(5, 5, 32'h0000_2824, 32'h4084_A090, 5, 2, 7'b0100000)};
        tbl[4]  = '{32'h0040_3025, mk(7, 0, 32'h0000_3025, 32'h4100_C094, 6, 3, 7'b0100000)};
        tbl[5]  = '{32'h0022_382A, mk(5, 7, 32'h0000_382A, 32'h4088_E0A8, 7, 4, 7'b0100000)};
        tbl[6]  = '{32'h2028_FFFF, mk(5, 0, 32'hFFFF_FFFF, 32'h40A3_FFFC, 8, 0, 7'b1100000)};
        tbl[7]  = '{32'hAC22_0008, mk(5, 7, 32'h0000_0008, 32'h4088_0020, 0, 0, 7'b1001000)};
        tbl[8]  = '{32'h1022_FFFE, mk(5, 7, 32'hFFFF_FFFE, 32'h408B_FFF8, 0, 1, 7'b0000100)};
        tbl[9]  = '{32'hFC00_0000, mk(0, 0, 32'h0000_0000, 32'h4000_0000, 0, 0, 7'b0000001)};
        tbl[10] = '{32'h0022_1821, mk(5, 7, 32'h0000_1821, 32'h4088_6084, 0, 0, 7'b0000001)};
        tbl[11] = '{32'h0800_0040, mk(0, 0, 32'h0000_0040, 32'h4000_0100, 0, 0, 7'b0000010)};

        idle();
        do_reset();
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_bundle", dut_b(), 0);
        chk("reset_in_ready", bus.in_ready, 1);

        wb(1, 5);
        wb(2, 7);
        foreach (tbl[i]) begin
            send(tbl[i].inst);
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("tbl%0d_bundle", i), dut_b(), tbl[i].exp);
        end

        bus.wb_en = 1'b1; bus.wb_addr = 1; bus.wb_data = 32'hDEAD_BEEF;
        send(32'h0022_1820);
        chk("bypass_rs", bus.rs_val, 32'hDEAD_BEEF);
        chk("bypass_rt", bus.rt_val, 7);
        bus.wb_en = 1'b1; bus.wb_addr = 0; bus.wb_data = 32'h1234;
        send(32'h0002_1820);
        chk("bypass_r0", bus.rs_val, 0);

        send(32'h0022_1820);
        held = dut_b();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.Inst = 32'h0041_2022;
        bus.wb_en = 1'b1; bus.wb_addr = 1; bus.wb_data = 32'h1111_1111;
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_valid", c), bus.out_valid, 1);
            chk($sformatf("stall%0d_bundle", c), dut_b(), held);
            chk($sformatf("stall%0d_in_ready", c), bus.in_ready, 0);
        end
        bus.wb_en = 1'b0; bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", bus.in_ready, 1);
        send(32'h0041_2022);
        chk("unstall_rs", bus.rs_val, 7);
        chk("unstall_rt", bus.rt_val, 32'h1111_1111);

        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.Inst = 32'h0022_1820;
        bus.wb_en = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h99;
        #1;
        chk("flush_in_ready", bus.in_ready, 1);
        send(32'h0022_1820);
        chk("flush_valid", bus.out_valid, 0);
        send(32'h0120_1820);
        chk("flush_wb_kept", bus.rs_val, 32'h99);
        tick();
        chk("drain_valid", bus.out_valid, 0);

        send(32'h0022_1820);
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        chk("midstall_reset_valid", bus.out_valid, 0);
        chk("midstall_reset_bundle", dut_b(), 0);
        send(32'h0022_1820);
        chk("postreset_rs", bus.rs_val, 0);
        chk("postreset_rt", bus.rt_val, 0);

        do_reset();
        m_valid = 0;
        m_known = 1;
        m_b = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.Inst = rnd_inst();
            bus.pc_in = $urandom;
            bus.wb_en = $urandom_range(0, 1);
            bus.wb_addr = 5'($urandom_range(0, 3));
            bus.wb_data = $urandom;
            #1;
            rdy = !m_valid || bus.out_ready;
            xfer = bus.in_valid && rdy;
            chk("rnd_in_ready", bus.in_ready, rdy);
            if (reset) begin
                m_valid = 0;
                m_known = 1;
                m_b = '0;
                foreach (m_rf[i]) m_rf[i] = '0;
            end else begin
                if (bus.flush) begin
                    m_valid = 0;
                    m_known = 0;
                end else if (xfer) begin
                    m_valid = 1;
                    m_known = 1;
                    m_b = ref_decode(bus.Inst, bus.pc_in, m_read(bus.Inst[25:21]), m_read(bus.Inst[20:16]));
                end else if (bus.out_ready) begin
                    m_valid = 0;
                    m_known = 0;
                end
                if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
            end
            tick();
            chk("rnd_out_valid", bus.out_valid, m_valid);
            if (m_known) chk("rnd_bundle", dut_b(), m_b);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage directly downstream of the fetch block; consumes its 32-bit instruction word (plus PC) through a valid/ready handshake.
- Holds the 32x32 register file.
- Produces a registered ID/EX bundle: operands, sign-extended immediate, destination register and control signals for the execute stage.
- Supports pipeline stall (backpressure) and flush, and has one write-back port from the end of the pipe.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width (2^REG_AW registers).

Ports:
- clk  in  1  single clock, all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  Inst/pc_in hold a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- Inst  in  32  instruction word from fetch.
- pc_in  in  32  PC of Inst.
- flush  in  1  discard the registered bundle.
- out_valid  out  1  ID/EX bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- wb_en  in  1  register-file write enable.
- wb_addr  in  REG_AW  write address.
- wb_data  in  DATA_W  write data.
- pc_out  out  32  PC of the decoded instruction.
- rs_val, rt_val  out  DATA_W  operand values.
- imm_ext  out  32  Inst[15:0] sign-extended.
- jump_target  out  32  {pc_in[31:28], Inst[25:0], 2'b00}.
- dst  out  REG_AW  destination register.
- alu_op  out  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- alu_src_imm, reg_wr, mem_rd, mem_wr, branch, jump, illegal  out  1 each  control signals.

Behaviour:
- Reset (synchronous):
  - out_valid=0 and every bundle output =0.
  - All registers cleared to 0.
  - Reset has priority over every other input.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready.
  - On a transfer, the bundle is computed from Inst/pc_in and the register file, registered on that edge, and out_valid=1 next cycle. Latency is 1 cycle.
- Stall: out_valid && !out_ready. Bundle and out_valid hold unchanged and in_ready=0.
- Drain: no transfer and out_ready=1. out_valid goes to 0; bundle contents are don't-care.
- Flush:
  - Priority: reset > flush > load/hold.
  - out_valid=0 next cycle and any same-cycle transfer is discarded.
  - in_ready is not gated by flush.
  - Register-file writes still occur during flush.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Write happens on the edge when wb_en=1.
  - Write-through bypass: if wb_en && wb_addr==field && wb_addr!=0, the read returns wb_data in the same cycle.
- Decode (op=Inst[31:26], funct=Inst[5:0]):
  - op 0x00, funct 0x20/0x22/0x24/0x25/0x2A: alu_op add/sub/and/or/slt, dst=Inst[15:11], reg_wr=1.
  - op 0x00, any other funct: illegal=1.
  - op 0x08 addi: add, alu_src_imm=1, dst=Inst[20:16], reg_wr=1.
  - op 0x23 lw: add, alu_src_imm=1, mem_rd=1, dst=Inst[20:16], reg_wr=1.
  - op 0x2B sw: add, alu_src_imm=1, mem_wr=1.
  - op 0x04 beq: sub, branch=1.
  - op 0x02 j: jump=1.
  - Any other op: illegal=1.
  - Illegal instructions force all control signals to 0, but out_valid still asserts so the exception can be reported downstream.
  - Unused outputs (dst, alu_op) =0 whenever reg_wr=0 / not applicable.
- Simultaneous events:
  - Write-back to a register being read on the same transfer cycle: the bypass value is captured.
  - Stall concurrent with a wb_en write to rs: the held rs_val is NOT refreshed.

Test Plan:
- Reset, then write $1=5 and $2=7 via wb. Inst=0x00221820 (add $3,$1,$2), in_valid=1, out_ready=1 → next cycle: out_valid=1, rs_val=5, rt_val=7, dst=3, alu_op=000, reg_wr=1.
- Inst=0x8C25FFFC (lw $5,-4($1)) → imm_ext=0xFFFFFFFC, mem_rd=1, alu_src_imm=1, dst=5, reg_wr=1.
- Bypass: wb_en=1, wb_addr=1, wb_data=0xDEADBEEF in the same cycle as the add transfer → rs_val=0xDEADBEEF. Repeat with wb_addr=0 → register 0 still reads 0.
- Stall: out_ready=0 for 3 cycles → in_ready=0, bundle stable. out_ready=1 → the next instruction loads on the following edge.
- Flush asserted in the same cycle as a transfer → out_valid=0 next cycle. Reset asserted mid-stall → out_valid=0, $1 reads 0 afterwards.
- Inst=0xFC000000 → illegal=1, out_valid=1, reg_wr=mem_rd=mem_wr=branch=jump=0. Inst=0x08000040 with pc_in=0x40000000 → jump=1, jump_target=0x40000100.
